// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified-memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } arbState_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Which side owns the memory while in a BUSY state
  function automatic logic busyOwner(arbState_t s);
    return (s == D_BUSY) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/memory-stage/memory signal bundle around the arbiter
interface mem_arbiter_if;

  logic        if_req;
  logic [15:0] if_addr;
  logic        dm_en;
  logic        dm_write;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        if_stall;
  logic        if_done;
  logic [15:0] if_rdata;
  logic        Stall4;
  logic        Done4;
  logic [15:0] dm_rdata;

  // Environment view: pipeline stages and memory drive requests and responses
  modport master (
    output if_req, if_addr, dm_en, dm_write, dm_addr, dm_wdata, mem_done, mem_rdata,
    input  mem_req, mem_wr, mem_addr, mem_wdata, if_stall, if_done, if_rdata,
           Stall4, Done4, dm_rdata
  );

  // Arbiter view
  modport slave (
    input  if_req, if_addr, dm_en, dm_write, dm_addr, dm_wdata, mem_done, mem_rdata,
    output mem_req, mem_wr, mem_addr, mem_wdata, if_stall, if_done, if_rdata,
           Stall4, Done4, dm_rdata
  );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// rtl/mem_arb_starve_cnt.sv - saturating count of D grants made while fetch waits
module mem_arb_starve_cnt #(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic atLimit
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [3:0] cnt;

  // Clear wins over increment; count stops at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt < LIM)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign atLimit = (cnt >= LIM);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - D-priority arbiter for the single-ported unified memory
module mem_arbiter #(
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  import mem_arb_pkg::*;

  arbState_t   state;
  arbState_t   nextState;
  logic        grantD;
  logic        grantI;
  logic        finish;
  logic        finishOwner;
  logic        starved;
  logic        memReq;
  logic        memWr;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        ifDone;
  logic        done4;
  logic [15:0] ifRdata;
  logic [15:0] dmRdata;

  // A D grant only counts toward starvation while fetch is actually waiting
  mem_arb_starve_cnt #(.STARVE_LIM(STARVE_LIM)) uStarve (
    .clk     (clk),
    .rst     (rst),
    .inc     (grantD & bus.if_req),
    .clr     (grantI | ~bus.if_req),
    .atLimit (starved)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next state: grant from IDLE, return to IDLE on memory completion
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (grantD)      nextState = D_BUSY;
        else if (grantI) nextState = I_BUSY;
      end
      D_BUSY, I_BUSY: begin
        if (bus.mem_done) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Decoded actions: D wins unless fetch has been passed over STARVE_LIM times
  always_comb begin
    grantD      = 1'b0;
    grantI      = 1'b0;
    finish      = 1'b0;
    finishOwner = busyOwner(state);
    if (state == IDLE) begin
      if (bus.dm_en && (!bus.if_req || !starved)) grantD = 1'b1;
      else if (bus.if_req)                        grantI = 1'b1;
    end else begin
      finish = bus.mem_done;
    end
  end

  // Registered memory handshake, loaded from the granted side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memReq   <= 1'b0;
      memWr    <= 1'b0;
      memAddr  <= 16'h0000;
      memWdata <= 16'h0000;
    end else if (grantD) begin
      memReq   <= 1'b1;
      memWr    <= bus.dm_write;
      memAddr  <= bus.dm_addr;
      memWdata <= bus.dm_wdata;
    end else if (grantI) begin
      memReq   <= 1'b1;
      memWr    <= 1'b0;
      memAddr  <= bus.if_addr;
      memWdata <= 16'h0000;
    end else if (finish) begin
      memReq   <= 1'b0;
      memWr    <= 1'b0;
    end
  end

  // Completion: one-cycle done pulse and read-data capture for the owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifDone  <= 1'b0;
      done4   <= 1'b0;
      ifRdata <= 16'h0000;
      dmRdata <= 16'h0000;
    end else begin
      ifDone <= finish && (finishOwner == OWN_I);
      done4  <= finish && (finishOwner == OWN_D);
      if (finish && (finishOwner == OWN_I)) ifRdata <= bus.mem_rdata;
      // Stores leave the load register untouched
      if (finish && (finishOwner == OWN_D) && !memWr) dmRdata <= bus.mem_rdata;
    end
  end

  assign bus.mem_req   = memReq;
  assign bus.mem_wr    = memWr;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.if_done   = ifDone;
  assign bus.Done4     = done4;
  assign bus.if_rdata  = ifRdata;
  assign bus.dm_rdata  = dmRdata;
  // Stalls drop in the done cycle so each holding register advances once
  assign bus.Stall4    = bus.dm_en & ~done4;
  assign bus.if_stall  = bus.if_req & ~ifDone;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   numTests = 0;
  int   numFail  = 0;
  logic [5:0] order;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIM(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    numTests++;
    if (got !== exp) begin
      numFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReq(input int budget);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checkVal("waitReq", {15'd0, bus.mem_req}, 16'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.dm_en = 0; bus.dm_write = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_done = 0; bus.mem_rdata = 0;
    step(); step();
    checkVal("rstMemReq", {15'd0, bus.mem_req}, 16'd0);
    checkVal("rstMemWr",  {15'd0, bus.mem_wr}, 16'd0);
    checkVal("rstAddr",   bus.mem_addr, 16'h0000);
    checkVal("rstDone4",  {15'd0, bus.Done4}, 16'd0);
    checkVal("rstDmRd",   bus.dm_rdata, 16'h0000);
    checkVal("rstIfRd",   bus.if_rdata, 16'h0000);
    rst = 1'b0;
    step();

    // Lone load, memory answers 4 cycles after the request appears
    bus.dm_en = 1; bus.dm_write = 0; bus.dm_addr = 16'h0040;
    #1;
    checkVal("ldStallReq", {15'd0, bus.Stall4}, 16'd1);
    step();
    checkVal("ldMemReq",  {15'd0, bus.mem_req}, 16'd1);
    checkVal("ldMemAddr", bus.mem_addr, 16'h0040);
    checkVal("ldMemWr",   {15'd0, bus.mem_wr}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("ldStallHold", {15'd0, bus.Stall4}, 16'd1);
      checkVal("ldNoDone",    {15'd0, bus.Done4}, 16'd0);
    end
    bus.mem_done = 1; bus.mem_rdata = 16'hBEEF;
    step();
    bus.mem_done = 0;
    checkVal("ldDone4",   {15'd0, bus.Done4}, 16'd1);
    checkVal("ldStall0",  {15'd0, bus.Stall4}, 16'd0);
    checkVal("ldRdata",   bus.dm_rdata, 16'hBEEF);
    checkVal("ldReqDrop", {15'd0, bus.mem_req}, 16'd0);
    bus.dm_en = 0;
    step();
    checkVal("ldDonePulse", {15'd0, bus.Done4}, 16'd0);
    checkVal("ldNoRegrant", {15'd0, bus.mem_req}, 16'd0);

    // Lone store
    bus.dm_en = 1; bus.dm_write = 1; bus.dm_addr = 16'h0010; bus.dm_wdata = 16'h1234;
    step();
    checkVal("stMemReq",  {15'd0, bus.mem_req}, 16'd1);
    checkVal("stMemWr",   {15'd0, bus.mem_wr}, 16'd1);
    checkVal("stWdata",   bus.mem_wdata, 16'h1234);
    checkVal("stAddr",    bus.mem_addr, 16'h0010);
    step();
    bus.mem_done = 1; bus.mem_rdata = 16'h5555;
    step();
    bus.mem_done = 0;
    checkVal("stDone4",   {15'd0, bus.Done4}, 16'd1);
    checkVal("stRdKeep",  bus.dm_rdata, 16'hBEEF);
    bus.dm_en = 0; bus.dm_write = 0;
    step();
    checkVal("stDonePulse", {15'd0, bus.Done4}, 16'd0);

    // Simultaneous requests: D first, fetch keeps stalling until its own done
    bus.dm_en = 1; bus.dm_addr = 16'h0020; bus.if_req = 1; bus.if_addr = 16'h0100;
    step();
    checkVal("simDFirst", bus.mem_addr, 16'h0020);
    checkVal("simIfStall", {15'd0, bus.if_stall}, 16'd1);
    bus.mem_done = 1; bus.mem_rdata = 16'h1111;
    step();
    bus.mem_done = 0;
    checkVal("simDone4",   {15'd0, bus.Done4}, 16'd1);
    checkVal("simIfStall2", {15'd0, bus.if_stall}, 16'd1);
    bus.dm_en = 0;
    step();
    checkVal("simIGrant",  {15'd0, bus.mem_req}, 16'd1);
    checkVal("simIAddr",   bus.mem_addr, 16'h0100);
    checkVal("simIWr",     {15'd0, bus.mem_wr}, 16'd0);
    checkVal("simIStall3", {15'd0, bus.if_stall}, 16'd1);
    bus.mem_done = 1; bus.mem_rdata = 16'hCAFE;
    step();
    bus.mem_done = 0;
    checkVal("simIfDone",  {15'd0, bus.if_done}, 16'd1);
    checkVal("simIfRdata", bus.if_rdata, 16'hCAFE);
    checkVal("simIfStall0", {15'd0, bus.if_stall}, 16'd0);
    checkVal("simNoDone4", {15'd0, bus.Done4}, 16'd0);
    bus.if_req = 0;
    step();
    checkVal("simIfPulse", {15'd0, bus.if_done}, 16'd0);

    // Starvation limit 2: expected grant order D D I D D I
    order = 6'd0;
    bus.dm_en = 1; bus.dm_write = 0; bus.dm_addr = 16'h0030;
    bus.if_req = 1; bus.if_addr = 16'h0200;
    for (int g = 0; g < 6; g++) begin
      waitReq(8);
      order = {order[4:0], bus.mem_addr == 16'h0030};
      step();
      bus.mem_done = 1; bus.mem_rdata = 16'(16'h0A00 + g);
      step();
      bus.mem_done = 0;
      checkVal("doneExcl",  {15'd0, bus.Done4 & bus.if_done}, 16'd0);
      checkVal("donePulse", {15'd0, bus.Done4 | bus.if_done}, 16'd1);
    end
    bus.dm_en = 0; bus.if_req = 0;
    checkVal("starveOrder", {10'd0, order}, 16'b110110);
    step();

    // Reset in D_BUSY before completion
    bus.dm_en = 1; bus.dm_addr = 16'h0040;
    step();
    checkVal("rmReq", {15'd0, bus.mem_req}, 16'd1);
    step();
    rst = 1'b1;
    #1;
    checkVal("rmReqDrop", {15'd0, bus.mem_req}, 16'd0);
    checkVal("rmAddr",    bus.mem_addr, 16'h0000);
    bus.dm_en = 0;
    step();
    checkVal("rmNoDone4", {15'd0, bus.Done4}, 16'd0);
    rst = 1'b0;
    step();
    bus.mem_done = 1; bus.mem_rdata = 16'h7777;
    step();
    bus.mem_done = 0;
    checkVal("rmIgnDone4", {15'd0, bus.Done4}, 16'd0);
    checkVal("rmIgnIfDn",  {15'd0, bus.if_done}, 16'd0);
    checkVal("rmIgnRd",    bus.dm_rdata, 16'h0000);
    checkVal("rmIgnReq",   {15'd0, bus.mem_req}, 16'd0);

    // Idle state confirmed by a fresh request being granted one cycle later
    bus.dm_en = 1; bus.dm_addr = 16'h0050;
    step();
    checkVal("rmRegrant", bus.mem_addr, 16'h0050);
    bus.mem_done = 1; bus.mem_rdata = 16'h4242;
    step();
    bus.mem_done = 0;
    bus.dm_en = 0;
    checkVal("rmRecover", bus.dm_rdata, 16'h4242);
    step();

    $display("[TB] %0d tests run, %0d failed", numTests, numFail);
    $finish;
  end

endmodule
